mac_row_feeder: RTL
===================

# mac_row_feeder

West-edge feeder for one row of the systolic MAC array. Buffers weight and activation words from the upstream loader in a small FIFO, then drives the row's first tile with the tile instruction protocol. It first issues a kernel-load burst of `col` weights with `inst=2'b01`. Afterwards it issues execute streams of activations with `inst=2'b10`, and inserts bubbles (`2'b00`) when data runs out.

## Interface
- `bw`, 4, data word width; matches tile `bw`
- `col`, 8, tiles per row, which sets the kernel-load burst length
- `depth`, 16, FIFO entries; a power of two, at least `col`
- `clk`  in  1  clock; all logic updates on the rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `wr`  in  1  push `in` into the FIFO; ignored when `full`
- `in`  in  `bw`  word to push
- `cmd_load`  in  1  single-cycle pulse that requests the kernel-load burst
- `cmd_exec`  in  1  single-cycle pulse that requests an execute stream of `exec_len` words
- `exec_len`  in  8  activation count, sampled together with `cmd_exec`; a value of 0 is legal and issues nothing
- `out_e`  out  `bw`  registered data to tile 0 `in_w`
- `inst_e`  out  2  registered instruction to tile 0 `inst_w`: bit 1 is execute, bit 0 is kernel load
- `full`, `empty`  out  1  FIFO status
- `busy`  out  1  high when not in IDLE, or when a command is pending
- `loaded`  out  1  high once the kernel burst has completed
- `done`  out  1  one-cycle pulse at the end of each burst

## Operation
- FIFO:
  - circular buffer with `depth` entries and a `log2(depth)+1` bit count.
  - A push and a pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo `depth`.
  - A push when `full` is dropped, even if a pop occurs in the same cycle.
- FSM states: IDLE, LOAD, EXEC, GAP.
- IDLE:
  - `cmd_load` with `loaded=0` sets `load_pend`.
  - `cmd_exec` with `loaded=1` sets `exec_pend` and latches `exec_len` into `remain`.
  - `cmd_load` while `loaded=1`, or `cmd_exec` while `loaded=0`, is ignored. Tiles accept only one kernel per reset.
  - If both commands arrive in the same cycle, `cmd_load` wins and `cmd_exec` is dropped.
  - Commands arriving outside IDLE, or while a command is pending, are ignored.
- `load_pend`:
  - The transition to LOAD happens only when count ≥ `col`, so the load burst is never interrupted.
  - A stalled load inserts no bubbles because tile 0 holds `a_q` on inst `00`.
- LOAD:
  - Pop one word per cycle and drive `out_e=word`, `inst_e=2'b01` for exactly `col` cycles.
  - The word order is tile 0's weight first, tile `col-1`'s weight last.
  - Then go to GAP and set `loaded`.
- `exec_pend`:
  - If `remain=0`, go directly to GAP.
  - Otherwise go to EXEC on the next cycle.
- EXEC:
  - Each cycle with the FIFO non-empty: pop, drive `out_e=word`, `inst_e=2'b10`, and decrement `remain`.
  - Each cycle with the FIFO empty: drive `inst_e=2'b00` and hold `out_e`.
  - When `remain` reaches 0 after a pop, go to GAP.
- GAP:
  - One cycle with `inst_e=2'b00` and `out_e` held; `done=1` in this cycle.
  - Then return to IDLE.
- `loaded` clears only on `reset`.

## Timing
- Reset values:
  - `out_e=0`, `inst_e=2'b00`, `full=0`, `empty=1`, `busy=0`, `loaded=0`, `done=0`.
  - FIFO count and pointers are 0, `remain=0`, no command pending, state is IDLE.
- `full` and `empty` are registered from the count and reflect a push at edge k from cycle k+1.
- Load latency:
  - `cmd_load` is sampled at edge k with count ≥ `col`.
  - The first weight appears on `out_e` in cycle k+2: one cycle for pending, one for the output register.
  - `inst_e=01` holds for cycles k+2 … k+col+1.
  - GAP and `done` occur in cycle k+col+2.
- Exec latency: `cmd_exec` at edge k with data available puts the first activation in cycle k+2.
- A pop reads the FIFO head, and the word is registered onto `out_e` at that same edge.
- Reset mid-burst:
  - The next cycle shows reset values.
  - FIFO contents are discarded (count is 0).
  - `loaded=0`, so a new load is accepted, matching the tiles, which also re-arm on `reset`.

## Test plan
- Load only:
  - Stimulus: reset, push 1…8 (`col=8`), pulse `cmd_load`.
  - Required: `inst_e=01` with `out_e`=1,2,…,8 on 8 consecutive cycles, then one `00` cycle with `done=1`, then `loaded=1` and `empty=1`.
- Stalled load:
  - Stimulus: push 5 words, pulse `cmd_load`, wait 10 cycles, then push 3 more.
  - Required: `inst_e` stays `00` until count reaches 8, then an unbroken 8-cycle `01` burst.
- Execute with bubbles:
  - Stimulus: after load, pulse `cmd_exec` with `exec_len=4`, push 9 and A, gap 3 cycles, push B and C.
  - Required: `10`/9, `10`/A, three `00` cycles with `out_e` held at A, then `10`/B, `10`/C, then GAP with `done`.
- Illegal commands:
  - Stimulus 1: `cmd_exec` before load. Required: ignored, `busy=0`.
  - Stimulus 2: a second `cmd_load` after `loaded`. Required: ignored.
  - Stimulus 3: simultaneous `cmd_load` and `cmd_exec` in IDLE. Required: only the load burst occurs.
- FIFO boundaries:
  - Stimulus: push 17 words with `depth=16`.
  - Required: `full=1` after 16 pushes and the 17th word is dropped.
  - Stimulus: drain and refill across the wrap point. Required: FIFO order is preserved.
- Reset mid-EXEC:
  - Stimulus: assert `reset` in the 2nd cycle of an EXEC burst.
  - Required: next cycle shows all reset values, then a fresh load of 8 words is accepted and replays correctly.

Source files
------------

// File: rtl/mac_row_feeder.sv
// West-edge feeder for one systolic MAC row: buffers loader words in a FIFO and
// drives tile 0 with a kernel-load burst followed by execute streams.
module mac_row_feeder #(
    parameter int bw    = 4,
    parameter int col   = 8,
    parameter int depth = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [bw-1:0] in,
    input  logic          cmd_load,
    input  logic          cmd_exec,
    input  logic [7:0]    exec_len,
    output logic [bw-1:0] out_e,
    output logic [1:0]    inst_e,
    output logic          full,
    output logic          empty,
    output logic          busy,
    output logic          loaded,
    output logic          done
);
    localparam int aw  = $clog2(depth);
    localparam int cw  = aw + 1;
    localparam int bcw = $clog2(col + 1);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_load = 2'd1;
    localparam logic [1:0] st_exec = 2'd2;
    localparam logic [1:0] st_gap  = 2'd3;

    localparam logic [1:0] inst_nop  = 2'b00;
    localparam logic [1:0] inst_kern = 2'b01;
    localparam logic [1:0] inst_run  = 2'b10;

    logic [bw-1:0]  mem [depth];
    logic [aw-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [cw-1:0]  count_reg, count_next;
    logic           full_reg, empty_reg;
    logic           push, pop;
    logic [bw-1:0]  head;

    logic [1:0]     state_reg, state_next;
    logic [bw-1:0]  out_e_reg, out_e_next;
    logic [1:0]     inst_e_reg, inst_e_next;
    logic           done_reg, done_next;
    logic           loaded_reg, loaded_next;
    logic           load_pend_reg, load_pend_next;
    logic           exec_pend_reg, exec_pend_next;
    logic [7:0]     remain_reg, remain_next;
    logic [bcw-1:0] beat_reg, beat_next;

    // A full FIFO drops the push even when a pop frees a slot in the same cycle.
    assign push       = wr && !full_reg;
    assign head       = mem[rd_ptr_reg];
    assign count_next = count_reg + cw'(push) - cw'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + aw'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + aw'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == cw'(depth));
            empty_reg <= (count_next == '0);
        end
    end

    // The state names what the output register shows; each pop loads out_e directly.
    always_comb begin
        state_next     = state_reg;
        pop            = 1'b0;
        out_e_next     = out_e_reg;
        inst_e_next    = inst_nop;
        done_next      = 1'b0;
        loaded_next    = loaded_reg;
        load_pend_next = load_pend_reg;
        exec_pend_next = exec_pend_reg;
        remain_next    = remain_reg;
        beat_next      = beat_reg;
        case (state_reg)
            st_idle: begin
                if (load_pend_reg) begin
                    // Wait for a whole kernel so the burst never stalls mid-way.
                    if (count_reg >= cw'(col)) begin
                        pop            = 1'b1;
                        out_e_next     = head;
                        inst_e_next    = inst_kern;
                        beat_next      = bcw'(1);
                        load_pend_next = 1'b0;
                        state_next     = st_load;
                    end
                end else if (exec_pend_reg) begin
                    exec_pend_next = 1'b0;
                    if (remain_reg == 8'd0) begin
                        done_next  = 1'b1;
                        state_next = st_gap;
                    end else begin
                        state_next = st_exec;
                        if (!empty_reg) begin
                            pop         = 1'b1;
                            out_e_next  = head;
                            inst_e_next = inst_run;
                            remain_next = remain_reg - 8'd1;
                        end
                    end
                end else if (cmd_load) begin
                    if (!loaded_reg) begin
                        load_pend_next = 1'b1;
                    end
                end else if (cmd_exec && loaded_reg) begin
                    exec_pend_next = 1'b1;
                    remain_next    = exec_len;
                end
            end
            st_load: begin
                if (beat_reg < bcw'(col)) begin
                    pop         = 1'b1;
                    out_e_next  = head;
                    inst_e_next = inst_kern;
                    beat_next   = beat_reg + bcw'(1);
                end else begin
                    done_next   = 1'b1;
                    loaded_next = 1'b1;
                    state_next  = st_gap;
                end
            end
            st_exec: begin
                if (remain_reg == 8'd0) begin
                    done_next  = 1'b1;
                    state_next = st_gap;
                end else if (!empty_reg) begin
                    pop         = 1'b1;
                    out_e_next  = head;
                    inst_e_next = inst_run;
                    remain_next = remain_reg - 8'd1;
                end
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= st_idle;
            out_e_reg     <= '0;
            inst_e_reg    <= inst_nop;
            done_reg      <= 1'b0;
            loaded_reg    <= 1'b0;
            load_pend_reg <= 1'b0;
            exec_pend_reg <= 1'b0;
            remain_reg    <= '0;
            beat_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_e_reg     <= out_e_next;
            inst_e_reg    <= inst_e_next;
            done_reg      <= done_next;
            loaded_reg    <= loaded_next;
            load_pend_reg <= load_pend_next;
            exec_pend_reg <= exec_pend_next;
            remain_reg    <= remain_next;
            beat_reg      <= beat_next;
        end
    end

    assign out_e  = out_e_reg;
    assign inst_e = inst_e_reg;
    assign full   = full_reg;
    assign empty  = empty_reg;
    assign busy   = (state_reg != st_idle) || load_pend_reg || exec_pend_reg;
    assign loaded = loaded_reg;
    assign done   = done_reg;
endmodule
